jt12_kon_latch: RTL
===================

// Module: jt12_kon_latch
// PURPOSE
//   CPU-side capture of the key-on register (0x28) and mode register (0x27) for the FM core.
//   Decodes host address/data writes and presents keyon_op/keyon_ch/up_keyon/csm to the key-on shift stage.
//   Holds up_keyon for one full 24-slot operator round, so every slot of the target channel samples the new key state.
// PARAMETERS
//   num_ch   6   channel count; 6 = YM2612/YM2610 style (ch codes 0,1,2,4,5,6), 3 = YM2203 style (codes 0,1,2 only)
//   hold     24  clk_en pulses up_keyon stays high after an accepted key-on write (one operator round)
// PORTS
//   rst         in   1  asynchronous reset, active-high
//   clk         in   1  core clock
//   clk_en      in   1  slot advance enable; one pulse = one operator slot
//   cpu_wr      in   1  single-clk write strobe, sampled every clk regardless of clk_en
//   cpu_addr    in   2  {A1,A0}: A0=0 address write, A0=1 data write; A1 = part (0 = I, 1 = II)
//   cpu_din     in   8  write data
//   keyon_op    out  4  operator mask {S4,S3,S2,S1} = cpu_din[7:4] of last accepted 0x28 write
//   keyon_ch    out  3  channel code = cpu_din[2:0] of last accepted 0x28 write
//   up_keyon    out  1  key-on update pending; consumer overrides its shift-chain value while high
//   csm         out  1  CSM mode, set when 0x27 data[7:6]==2'b10
//   busy        out  1  equals up_keyon; host must not issue another 0x28 write while high
// BEHAVIOUR
//   Reset (async): keyon_op=0, keyon_ch=0, up_keyon=0, busy=0, csm=0, sel_reg=0, sel_part=0, counter=0.
//   Address write (cpu_wr & A0=0): sel_reg <= cpu_din, sel_part <= A1 on that clk edge. No other effect.
//   Data write (cpu_wr & A0=1) is accepted only when A1==sel_part. sel_reg is not cleared by data writes.
//   0x28 accept: requires sel_part=0, sel_reg=8'h28 and a valid cpu_din[2:0].
//     Valid codes: num_ch=6: 0,1,2,4,5,6. num_ch=3: 0,1,2.
//     Invalid codes (3, 7, or 4..6 when num_ch=3) are dropped; outputs unchanged, counter unchanged.
//   0x28 effect, on the same clk edge: keyon_op, keyon_ch <= data; up_keyon <= 1; counter <= hold.
//     The clk_en in the write cycle does not count toward hold.
//   0x27 accept (sel_part=0, sel_reg=8'h27): csm <= (cpu_din[7:6]==2'b10) on that edge; other bits ignored here.
//     0x27 and 0x28 writes in part II are ignored.
//   Hold counter: only while up_keyon=1 and no accepted 0x28 write that cycle.
//     Each clk_en pulse decrements the counter.
//     On the edge where the counter goes 1->0, up_keyon <= 0. High for exactly hold clk_en pulses.
//   keyon_op/keyon_ch keep their last values after up_keyon falls (consumer ignores them while up_keyon=0).
//   Accepted 0x28 write while up_keyon=1: new values replace old, counter reloads to hold (last write wins).
//     No gap cycle on up_keyon.
//   clk_en held low: counter frozen, up_keyon stays high indefinitely; writes are still captured.
//   Write strobe wider than 1 clk: each high clk is a separate write. Reloads are idempotent for equal data.
//   Reset asserted mid-hold: all state clears immediately. First post-reset 0x28 write starts a fresh hold.
//   All outputs are registered; no combinational path from cpu_* to outputs.
// TESTING
//   reset -> all outputs 0.
//   addr 0x28 (A=00), data 0xF2 (A=01) -> next edge: keyon_op=4'hF, keyon_ch=2, up_keyon=1.
//     up_keyon falls on the 24th subsequent clk_en, with clk_en=1 every 2nd clk.
//   data 0x13 and data 0x17 -> no output change.
//     With num_ch=3, data 0x14 -> no change. With num_ch=6, data 0x14 -> keyon_ch=4.
//   write 0xF0 and, 10 clk_en later, write 0x01 -> keyon_op=0, keyon_ch=1.
//     up_keyon continuous, ending 24 clk_en after the second write.
//   addr 0x28 with A1=1, then data 0xF0 with A1=1 -> ignored.
//     addr 0x27, data 0x80 -> csm=1. Data 0xC0 -> csm=0.
//   rst pulse 5 clk_en into a hold -> up_keyon=0 asynchronously, keyon_op=0.
//     The next valid write gives a full 24-pulse hold.

Source files
------------

// File: rtl/jt12_kon_latch.sv
// Host-side latch for the key-on (0x28) and mode (0x27) registers of the FM core.
// A key-on write raises up_keyon for exactly `hold` clk_en pulses (one operator round).
module jt12_kon_latch #(
  parameter int unsigned num_ch = 6,
  parameter int unsigned hold   = 24
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       clk_en,
  input  logic       cpu_wr,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [3:0] keyon_op,
  output logic [2:0] keyon_ch,
  output logic       up_keyon,
  output logic       csm,
  output logic       busy
);

  localparam int unsigned cnt_w = $clog2(hold + 1);
  localparam logic [cnt_w-1:0] hold_val = cnt_w'(hold);
  localparam logic [cnt_w-1:0] cnt_one  = cnt_w'(1);

  logic [7:0]       sel_reg_q, sel_reg_d;
  logic             sel_part_q, sel_part_d;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       ch_q, ch_d;
  logic             up_q, up_d;
  logic             csm_q, csm_d;

  logic addr_wr, data_wr, part1_wr, code_ok, kon_wr, mode_wr;

  assign addr_wr  = cpu_wr & ~cpu_addr[0];
  // Data writes only land in the part that was last addressed.
  assign data_wr  = cpu_wr & cpu_addr[0] & (cpu_addr[1] == sel_part_q);
  assign part1_wr = data_wr & ~sel_part_q;

  // Channel codes 3 and 7 never exist; 3-channel parts also lack the upper bank.
  always_comb begin
    code_ok = 1'b0;
    if (num_ch == 3) begin
      code_ok = (cpu_din[2:0] < 3'd3);
    end else begin
      code_ok = (cpu_din[1:0] != 2'b11);
    end
  end

  assign kon_wr  = part1_wr & (sel_reg_q == 8'h28) & code_ok;
  assign mode_wr = part1_wr & (sel_reg_q == 8'h27);

  always_comb begin
    sel_reg_d  = sel_reg_q;
    sel_part_d = sel_part_q;
    op_d       = op_q;
    ch_d       = ch_q;
    up_d       = up_q;
    cnt_d      = cnt_q;
    csm_d      = csm_q;

    if (addr_wr) begin
      sel_reg_d  = cpu_din;
      sel_part_d = cpu_addr[1];
    end

    if (mode_wr) begin
      csm_d = (cpu_din[7:6] == 2'b10);
    end

    // A fresh key-on reloads the round; the write cycle's clk_en is not counted.
    if (kon_wr) begin
      op_d  = cpu_din[7:4];
      ch_d  = cpu_din[2:0];
      up_d  = 1'b1;
      cnt_d = hold_val;
    end else if (up_q && clk_en) begin
      cnt_d = cnt_q - cnt_one;
      if (cnt_q == cnt_one) begin
        up_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg_q  <= 8'h00;
      sel_part_q <= 1'b0;
      op_q       <= 4'h0;
      ch_q       <= 3'd0;
      up_q       <= 1'b0;
      cnt_q      <= '0;
      csm_q      <= 1'b0;
    end else begin
      sel_reg_q  <= sel_reg_d;
      sel_part_q <= sel_part_d;
      op_q       <= op_d;
      ch_q       <= ch_d;
      up_q       <= up_d;
      cnt_q      <= cnt_d;
      csm_q      <= csm_d;
    end
  end

  assign keyon_op = op_q;
  assign keyon_ch = ch_q;
  assign up_keyon = up_q;
  assign busy     = up_q;
  assign csm      = csm_q;

endmodule
